// File: rtl/scale_arbiter.sv
// scale_arbiter: round-robin front end that shares one Q-format vector-scale
// unit among NUM_REQ requester FIFOs. One transaction is in flight at a time:
// the winner's operands are latched and presented as an FWFT source, and the
// scale unit's result is steered back into the winner's result FIFO.
// Vector ports are flattened: lane k of requester i sits at bit (i*3+k)*32.

module scale_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int Q_BITS  = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ*96-1:0]  req_x,
  input  logic [NUM_REQ*32-1:0]  req_a,
  input  logic [NUM_REQ-1:0]     req_empty,
  output logic [NUM_REQ-1:0]     req_rd_en,
  output logic [95:0]            sc_x,
  output logic [31:0]            sc_a,
  output logic                   sc_empty,
  input  logic                   sc_rd_en,
  input  logic [95:0]            sc_out,
  input  logic                   sc_wr_en,
  output logic                   sc_full,
  output logic [95:0]            res_out,
  output logic [NUM_REQ-1:0]     res_wr_en,
  input  logic [NUM_REQ-1:0]     res_full,
  output logic                   busy,
  output logic [15:0]            txn_count
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [ID_W-1:0]   cur_id_q, cur_id_d;
  logic [95:0]       hold_x_q, hold_x_d;
  logic [31:0]       hold_a_q, hold_a_d;
  logic [15:0]       txn_count_q, txn_count_d;

  logic [NUM_REQ-1:0] eligible_s;
  logic               win_found_s;
  logic [ID_W-1:0]    win_id_s;
  logic [ID_W:0]      cand_s;

  // A requester whose result FIFO is full is skipped so it cannot block others.
  assign eligible_s = ~req_empty & ~res_full;

  // Round-robin search starting just after the last requester served.
  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = {ID_W{1'b0}};
    cand_s      = {(ID_W+1){1'b0}};
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s = {1'b0, last_grant_q} + (ID_W+1)'(k);
      if (cand_s >= (ID_W+1)'(NUM_REQ)) begin
        cand_s = cand_s - (ID_W+1)'(NUM_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!win_found_s && eligible_s[cand_s[ID_W-1:0]]) begin
        win_found_s = 1'b1;
        win_id_s    = cand_s[ID_W-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state and handshake strobes; pops and result writes are suppressed
  // while reset is held so no FIFO entry is consumed and then discarded.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cur_id_d     = cur_id_q;
    hold_x_d     = hold_x_q;
    hold_a_d     = hold_a_q;
    txn_count_d  = txn_count_q;
    req_rd_en    = {NUM_REQ{1'b0}};
    res_wr_en    = {NUM_REQ{1'b0}};
    sc_empty     = 1'b1;
    sc_full      = 1'b1;
    busy         = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (win_found_s && !reset) begin
          req_rd_en[win_id_s] = 1'b1;
          hold_x_d = req_x[int'(win_id_s)*96 +: 96];
          hold_a_d = req_a[int'(win_id_s)*32 +: 32];
          cur_id_d = win_id_s;
          state_d  = ST_LOAD;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_LOAD: begin
        sc_empty = 1'b0;
        if (sc_rd_en) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_WAIT: begin
        sc_full = res_full[cur_id_q];
        if (sc_wr_en && !res_full[cur_id_q] && !reset) begin
          res_wr_en[cur_id_q] = 1'b1;
          last_grant_d = cur_id_q;
          txn_count_d  = txn_count_q + 16'd1;
          state_d      = ST_IDLE;
        end else begin
          state_d      = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and operand hold registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      cur_id_q     <= {ID_W{1'b0}};
      hold_x_q     <= 96'd0;
      hold_a_q     <= 32'd0;
      txn_count_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cur_id_q     <= cur_id_d;
      hold_x_q     <= hold_x_d;
      hold_a_q     <= hold_a_d;
      txn_count_q  <= txn_count_d;
    end
  end

  assign sc_x      = hold_x_q;
  assign sc_a      = hold_a_q;
  assign res_out   = sc_out;
  assign txn_count = txn_count_q;

  scale_arbiter_chk #(
    .NUM_REQ (NUM_REQ),
    .Q_BITS  (Q_BITS)
  ) u_chk (
    .clock     (clock),
    .reset     (reset),
    .req_rd_en (req_rd_en),
    .res_wr_en (res_wr_en),
    .in_load   (state_q == ST_LOAD),
    .in_wait   (state_q == ST_WAIT),
    .sc_rd_en  (sc_rd_en),
    .sc_wr_en  (sc_wr_en)
  );

endmodule

// Protocol checker: one-hot strobes and scale-unit handshakes only in the
// state that accepts them.
module scale_arbiter_chk #(
  parameter int NUM_REQ = 2,
  parameter int Q_BITS  = 10
) (
  input logic               clock,
  input logic               reset,
  input logic [NUM_REQ-1:0] req_rd_en,
  input logic [NUM_REQ-1:0] res_wr_en,
  input logic               in_load,
  input logic               in_wait,
  input logic               sc_rd_en,
  input logic               sc_wr_en
);

  a_rd_onehot: assert property (@(posedge clock) disable iff (reset) $onehot0(req_rd_en));
  a_wr_onehot: assert property (@(posedge clock) disable iff (reset) $onehot0(res_wr_en));
  a_rd_proto:  assert property (@(posedge clock) disable iff (reset) sc_rd_en |-> in_load);
  a_wr_proto:  assert property (@(posedge clock) disable iff (reset) sc_wr_en |-> in_wait);
  a_qbits:     assert property (@(posedge clock) (Q_BITS >= 0) && (Q_BITS < 32));

endmodule

// File: tb/tb_scale_arbiter.sv
// Bench for scale_arbiter with four requesters. The bench plays the scale unit
// and the FIFOs, and checks every cycle against a transaction-level model.
module tb_scale_arbiter;
  localparam int NREQ = 4;
  localparam int Q    = 10;

  logic              clock = 1'b0;
  logic              reset;
  logic [NREQ*96-1:0] req_x;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ-1:0]   req_empty, req_rd_en, res_wr_en, res_full;
  logic [95:0]       sc_x, sc_out, res_out;
  logic [31:0]       sc_a;
  logic              sc_empty, sc_rd_en, sc_wr_en, sc_full, busy;
  logic [15:0]       txn_count;

  scale_arbiter #(.NUM_REQ(NREQ), .Q_BITS(Q)) dut (
    .clock(clock), .reset(reset), .req_x(req_x), .req_a(req_a),
    .req_empty(req_empty), .req_rd_en(req_rd_en), .sc_x(sc_x), .sc_a(sc_a),
    .sc_empty(sc_empty), .sc_rd_en(sc_rd_en), .sc_out(sc_out), .sc_wr_en(sc_wr_en),
    .sc_full(sc_full), .res_out(res_out), .res_wr_en(res_wr_en), .res_full(res_full),
    .busy(busy), .txn_count(txn_count));

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // model state: 0 idle, 1 operands offered, 2 awaiting result
  int          m_phase = 0;
  int          m_last  = NREQ - 1;
  int          m_count = 0;
  int          m_id    = 0;
  logic [95:0] m_x;
  logic [31:0] m_a;
  int          done_per [NREQ];

  // scale-unit stand-in
  int          su_st  = 0;
  int          su_dly = 0;
  bit          su_rand = 1'b0;
  logic [95:0] su_res;

  bit          hold_data = 1'b0;
  int          cyc = 0, g_cyc = 0, w_cyc = 0;
  logic [3:0]  pop_cap, wr_cap, s_wr;
  logic [95:0] wr_data;
  logic        s_full;

  typedef struct {
    logic [3:0] empty;
    logic [3:0] full;
    logic [3:0] exp_pop;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [95:0] scale3(input logic [95:0] x, input logic [31:0] a);
    logic [95:0] r;
    longint p;
    r = 96'd0;
    for (int k = 0; k < 3; k++) begin
      p = longint'($signed(x[k*32 +: 32])) * longint'($signed(a));
      p = p >>> Q;
      r[k*32 +: 32] = p[31:0];
    end
    return r;
  endfunction

  // One clock cycle: drive strobes at the falling edge, check at +1, then
  // cross the rising edge and return at the next falling edge.
  task automatic tick();
    int w;
    logic [3:0] e;
    if (reset) begin
      su_st = 0; su_dly = 0; sc_rd_en = 1'b0; sc_wr_en = 1'b0;
    end else begin
      sc_rd_en = 1'b0;
      if (su_st == 2) begin
        sc_wr_en = 1'b0; su_st = 0;
        su_dly = su_rand ? $urandom_range(0, 2) : 0;
      end
      if (su_st == 0 && !sc_empty) begin
        if (su_dly == 0) sc_rd_en = 1'b1; else su_dly--;
      end else if (su_st == 1 && !sc_wr_en) begin
        if (su_dly == 0) begin sc_wr_en = 1'b1; sc_out = su_res; end else su_dly--;
      end
    end
    if (!hold_data) begin
      for (int i = 0; i < NREQ*3; i++) req_x[i*32 +: 32] = $urandom;
      for (int i = 0; i < NREQ; i++)   req_a[i*32 +: 32] = $urandom;
    end
    #1;
    s_wr = res_wr_en; s_full = sc_full;
    if (req_rd_en != 4'd0) begin pop_cap = req_rd_en; g_cyc = cyc; end
    if (res_wr_en != 4'd0) begin wr_cap = res_wr_en; wr_data = res_out; w_cyc = cyc; end
    if (reset) begin
      chk("rst_rd_gate", req_rd_en, 4'd0);
      chk("rst_wr_gate", res_wr_en, 4'd0);
    end else begin
      chk("txn_count", txn_count, 16'(m_count));
      if (m_phase == 0) begin
        w = -1;
        for (int k = 1; k <= NREQ; k++) begin
          int c;
          c = (m_last + k) % NREQ;
          if (w < 0 && !req_empty[c] && !res_full[c]) w = c;
        end
        e = 4'd0;
        if (w >= 0) e[w] = 1'b1;
        chk("idle_pop", req_rd_en, e);
        chk("idle_flags", {busy, sc_empty, sc_full, res_wr_en}, {1'b0, 1'b1, 1'b1, 4'd0});
        if (w >= 0) begin
          m_id = w; m_x = req_x[w*96 +: 96]; m_a = req_a[w*32 +: 32]; m_phase = 1;
        end
      end else if (m_phase == 1) begin
        chk("load_flags", {req_rd_en, busy, sc_empty, sc_full, res_wr_en},
            {4'd0, 1'b1, 1'b0, 1'b1, 4'd0});
        chk("load_ops", {sc_a, sc_x}, {m_a, m_x});
        if (sc_rd_en) m_phase = 2;
      end else begin
        e = 4'd0;
        if (sc_wr_en && !res_full[m_id]) e[m_id] = 1'b1;
        chk("wait_flags", {req_rd_en, busy, sc_empty, sc_full},
            {4'd0, 1'b1, 1'b1, res_full[m_id]});
        chk("wait_wr", res_wr_en, e);
        if (e != 4'd0) begin
          chk("wait_data", res_out, scale3(m_x, m_a));
          m_last = m_id; m_count = (m_count + 1) % 65536; done_per[m_id]++; m_phase = 0;
        end
      end
      if (sc_rd_en && !sc_empty && su_st == 0) begin
        su_res = scale3(sc_x, sc_a); su_st = 1;
        su_dly = su_rand ? $urandom_range(0, 2) : 0;
      end
      if (sc_wr_en && !sc_full && su_st == 1) su_st = 2;
    end
    @(posedge clock);
    if (reset) begin m_phase = 0; m_last = NREQ - 1; m_count = 0; end
    @(negedge clock);
    cyc++;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd"}, req_rd_en, 4'd0);
    chk({tag, "_wr"}, res_wr_en, 4'd0);
    chk({tag, "_flags"}, {sc_empty, sc_full, busy}, {1'b1, 1'b1, 1'b0});
    chk({tag, "_ops"}, {sc_a, sc_x}, 128'd0);
    chk({tag, "_cnt"}, txn_count, 16'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    chk_reset_vals("reset");
    reset = 1'b0;
  endtask

  // Run until one transaction completes (bounded); pop_cap keeps the grant.
  task automatic run_txn(input logic [3:0] empty, input logic [3:0] full);
    int start;
    int n;
    start = m_count; n = 0;
    req_empty = empty; res_full = full; pop_cap = 4'd0;
    while (m_count == start && n < 30) begin tick(); n++; end
    if (m_count == start) chk("txn_timeout", 1'b1, 1'b0);
  endtask

  task automatic wait_phase(input int ph);
    int n;
    n = 0;
    while (m_phase != ph && n < 20) begin tick(); n++; end
    if (m_phase != ph) chk("phase_timeout", ph, m_phase);
  endtask

  initial begin
    int n, mx, mn;
    reset = 1'b1; req_empty = 4'hF; res_full = 4'h0; sc_rd_en = 1'b0; sc_wr_en = 1'b0;
    sc_out = 96'd0; req_x = '0; req_a = '0;
    pop_cap = 4'd0; wr_cap = 4'd0; s_wr = 4'd0; s_full = 1'b0; wr_data = 96'd0;
    for (int i = 0; i < NREQ; i++) done_per[i] = 0;
    @(negedge clock);
    do_reset();

    // single op on req0 with known operands
    hold_data = 1'b1;
    req_x[0 +: 96] = {32'hFFFF_FC00, 32'd2048, 32'd1024};
    req_a[0 +: 32] = 32'd512;
    req_empty = 4'b1110; pop_cap = 4'd0; n = 0;
    while (pop_cap == 4'd0 && n < 10) begin tick(); n++; end
    chk("t1_pop", pop_cap, 4'b0001);
    req_empty = 4'b1111; wr_cap = 4'd0; n = 0;
    while (wr_cap == 4'd0 && n < 10) begin tick(); n++; end
    chk("t1_wr", wr_cap, 4'b0001);
    chk("t1_latency", w_cyc - g_cyc, 2);
    chk("t1_data", wr_data, {32'hFFFF_FE00, 32'd1024, 32'd512});
    chk("t1_count", txn_count, 16'd1);
    hold_data = 1'b0;

    // table of eligibility patterns, applied in order from last_grant=0
    tbl[0]  = '{4'b0000, 4'b0000, 4'b0010};
    tbl[1]  = '{4'b0000, 4'b0100, 4'b1000};
    tbl[2]  = '{4'b0000, 4'b0001, 4'b0010};
    tbl[3]  = '{4'b1101, 4'b0000, 4'b0010};
    tbl[4]  = '{4'b0111, 4'b0000, 4'b1000};
    tbl[5]  = '{4'b0000, 4'b0000, 4'b0001};
    tbl[6]  = '{4'b1111, 4'b0000, 4'b0000};
    tbl[7]  = '{4'b0000, 4'b1111, 4'b0000};
    tbl[8]  = '{4'b0010, 4'b0001, 4'b0100};
    tbl[9]  = '{4'b1011, 4'b0000, 4'b0100};
    tbl[10] = '{4'b0000, 4'b1000, 4'b0001};
    for (int v = 0; v < 11; v++) begin
      if (tbl[v].exp_pop == 4'd0) begin
        req_empty = tbl[v].empty; res_full = tbl[v].full; pop_cap = 4'd0;
        for (int c = 0; c < 6; c++) tick();
      end else begin
        run_txn(tbl[v].empty, tbl[v].full);
      end
      chk($sformatf("tbl%0d_grant", v), pop_cap, tbl[v].exp_pop);
    end

    // req0/req1 saturated: strict alternation from reset
    req_empty = 4'hF; res_full = 4'h0;
    do_reset();
    for (int j = 0; j < 8; j++) begin
      run_txn(4'b1100, 4'b0000);
      chk("t2_alt", pop_cap, (j % 2 == 0) ? 4'b0001 : 4'b0010);
    end

    // req1's result FIFO full: only req0 served, then req1 first
    for (int j = 0; j < 4; j++) begin
      run_txn(4'b1100, 4'b0010);
      chk("t3_skip", pop_cap, 4'b0001);
    end
    run_txn(4'b1100, 4'b0000);
    chk("t3_resume", pop_cap, 4'b0010);

    // result stall for five cycles in WAIT
    req_empty = 4'b1110; res_full = 4'h0;
    wait_phase(1);
    req_empty = 4'b1111;
    wait_phase(2);
    res_full = 4'b0001;
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("t4_stall", {s_full, s_wr}, {1'b1, 4'd0});
    end
    res_full = 4'b0000;
    tick();
    chk("t4_release", s_wr, 4'b0001);

    // reset while in LOAD, then while in WAIT
    req_empty = 4'b0000;
    wait_phase(1);
    reset = 1'b1; tick();
    chk_reset_vals("rst_load");
    reset = 1'b0; pop_cap = 4'd0; tick();
    chk("rst_load_first", pop_cap, 4'b0001);
    wait_phase(2);
    reset = 1'b1; tick();
    chk_reset_vals("rst_wait");
    reset = 1'b0; pop_cap = 4'd0; tick();
    chk("rst_wait_first", pop_cap, 4'b0001);

    // all four saturated with random scale-unit latency: fairness
    req_empty = 4'hF;
    do_reset();
    for (int i = 0; i < NREQ; i++) done_per[i] = 0;
    su_rand = 1'b1; req_empty = 4'h0; res_full = 4'h0; n = 0;
    while (m_count < 400 && n < 6000) begin tick(); n++; end
    chk("t6_count", txn_count, 16'd400);
    mx = done_per[0]; mn = done_per[0];
    for (int i = 1; i < NREQ; i++) begin
      if (done_per[i] > mx) mx = done_per[i];
      if (done_per[i] < mn) mn = done_per[i];
    end
    chk("t6_fair", (mx - mn) <= 1, 1'b1);

    // random FIFO flags, model checks each cycle
    for (int j = 0; j < 400; j++) begin
      req_empty = 4'($urandom);
      res_full  = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
